// File: rtl/comm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : comm_pkg                                               |
// | Description : Shared framing constants and types for the DA/AD link. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package comm_pkg;

  localparam int WORD_W         = 128;
  localparam int SAMPLE_W       = 6;
  localparam int BITS_PER_BEAT  = 2;
  localparam int BEATS_PER_WORD = WORD_W / BITS_PER_BEAT;
  localparam int BEAT_CNT_W     = $clog2(BEATS_PER_WORD);
  localparam int SYNC_W         = 16;

  // Framing defaults shared with the transmit block
  localparam logic [SYNC_W-1:0] DEF_SYNC_WORD = 16'hA5C3;
  localparam int                DEF_THRESH    = 32;

  // Legacy-compatible state encodings
  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_DATA = 1'b1;

  typedef enum logic [0:0] {
    HUNT = ST_HUNT,
    DATA = ST_DATA
  } state_e;

  // Offset-binary slicer: a sample at or above the threshold is a one
  function automatic logic slice(input logic [SAMPLE_W-1:0] s, input int thresh);
    return (32'(s) >= 32'(thresh));
  endfunction

endpackage
`default_nettype wire

// File: rtl/comm_recv_deser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : comm_recv_deser                                        |
// | Description : LSB-first 2-bit-per-beat deserialiser for 128-bit     |
// |               words; flags the beat that completes a word.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module comm_recv_deser
  import comm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     beat_valid,
  input  logic [BITS_PER_BEAT-1:0] beat_bits,
  output logic                     word_done,
  output logic [WORD_W-1:0]        word
);

  logic [WORD_W-1:0]     shift;
  logic [BEAT_CNT_W-1:0] beat_cnt;

  // Shifting right places beat 0 at bits [1:0] once all 64 beats are in
  assign word      = {beat_bits, shift[WORD_W-1:BITS_PER_BEAT]};
  assign word_done = beat_valid && (beat_cnt == BEAT_CNT_W'(BEATS_PER_WORD - 1));

  // Shift register and beat counter; the counter wraps so the next word starts without a gap
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      shift    <= '0;
      beat_cnt <= '0;
    end else if (beat_valid) begin
      shift    <= word;
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/comm_recv.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : comm_recv                                              |
// | Description : AD receive path: slicer, sync hunter, frame            |
// |               deserialiser and RX FIFO write side.                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module comm_recv
  import comm_pkg::*;
#(
  parameter int                THRESH          = DEF_THRESH,
  parameter logic [SYNC_W-1:0] SYNC_WORD       = DEF_SYNC_WORD,
  parameter int                WORDS_PER_FRAME = 1,
  parameter int                TIMEOUT         = 1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ad_valid,
  input  logic [SAMPLE_W-1:0] ad1,
  input  logic [SAMPLE_W-1:0] ad2,
  output logic                wr_en,
  output logic [WORD_W-1:0]   dout,
  input  logic                full,
  output logic                locked,
  output logic                overflow,
  output logic                timeout_err,
  output logic [15:0]         drop_cnt
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_e                   state;
  logic [SYNC_W-1:0]        sync_sr;
  logic [SYNC_W-1:0]        sync_next;
  logic [7:0]               word_cnt;
  logic [IDLE_W-1:0]        idle_cnt;
  logic [BITS_PER_BEAT-1:0] beat_bits;
  logic                     timeout_hit;
  logic                     data_beat;
  logic                     deser_clear;
  logic                     last_word;
  logic                     word_done;
  logic [WORD_W-1:0]        word;

  assign beat_bits   = {slice(ad2, THRESH), slice(ad1, THRESH)};
  assign sync_next   = {sync_sr[SYNC_W-BITS_PER_BEAT-1:0], beat_bits};
  // The timeout is checked before the beat, so a beat arriving on the timeout cycle is dropped
  assign timeout_hit = (state == DATA) && (idle_cnt == IDLE_W'(TIMEOUT));
  assign data_beat   = (state == DATA) && ad_valid && !timeout_hit;
  assign deser_clear = (state == HUNT) || timeout_hit;
  assign last_word   = (word_cnt == 8'(WORDS_PER_FRAME - 1));
  assign locked      = (state == DATA);

  comm_recv_deser u_deser (
    .clk        (CLK),
    .rst        (RST),
    .clear      (deser_clear),
    .beat_valid (data_beat),
    .beat_bits  (beat_bits),
    .word_done  (word_done),
    .word       (word)
  );

  // Framing FSM: hunt for the sync word, then count words and idle cycles
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= HUNT;
      sync_sr  <= '0;
      word_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        HUNT: begin
          word_cnt <= '0;
          idle_cnt <= '0;
          if (ad_valid) begin
            sync_sr <= sync_next;
            if (sync_next == SYNC_WORD) begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (timeout_hit) begin
            state    <= HUNT;
            sync_sr  <= '0;
            idle_cnt <= '0;
            word_cnt <= '0;
          end else begin
            if (ad_valid) begin
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
            if (word_done) begin
              if (last_word) begin
                state    <= HUNT;
                sync_sr  <= '0;
                word_cnt <= '0;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  // FIFO write side and status pulses, one cycle after the completing beat
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_en       <= 1'b0;
      dout        <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      wr_en       <= word_done && !full;
      overflow    <= word_done && full;
      timeout_err <= timeout_hit;
      if (word_done && !full) begin
        dout <= word;
      end
      if (word_done && full && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/comm_recv.md
Name: comm_recv

Overview:
Receive-side counterpart of the DA transmit path. It takes paired 6-bit AD samples, slices each sample to one bit, and hunts for a 16-bit sync word. After lock it deserialises a frame of 128-bit words and writes each word into the downstream receive FIFO using its write-side handshake (wr_en / full). It sits between the AD capture logic and the RX FIFO that feeds the host-side reader.

Parameters:
THRESH, 32, slicer threshold; a sample gives bit 1 when it is >= THRESH (unsigned offset-binary)
SYNC_WORD, 16'hA5C3, sync pattern compared against the last 8 sliced beats
WORDS_PER_FRAME, 1, number of 128-bit words collected after each sync match (1..255)
TIMEOUT, 1024, maximum idle cycles (ad_valid low) allowed inside a frame

Ports:
CLK  in  1  system clock
RST  in  1  reset; synchronous, active-high
ad_valid  in  1  ad1/ad2 carry a sample pair this cycle
ad1  in  6  sample, lane 1
ad2  in  6  sample, lane 2
wr_en  out  1  FIFO write strobe, one cycle per word
dout  out  128  word to the FIFO; valid while wr_en is high
full  in  1  FIFO full
locked  out  1  high while in DATA state
overflow  out  1  one-cycle pulse when a word is dropped because full=1
timeout_err  out  1  one-cycle pulse when a frame is aborted on timeout
drop_cnt  out  16  count of dropped words; saturates at 16'hFFFF

Behaviour:
- Reset (RST=1 at a CLK edge): state=HUNT, sync_sr=0, beat counter=0, word counter=0, idle counter=0, wr_en=0, dout=0, locked=0, overflow=0, timeout_err=0, drop_cnt=0. Reset applied mid-frame discards the partial word; no write is issued.
- Slicing: b1 = (ad1 >= THRESH), b2 = (ad2 >= THRESH). Each beat carries the 2-bit pair {b2,b1}. The slicer is combinational.
- HUNT:
  - On each ad_valid, sync_sr <= {sync_sr[13:0], b2, b1}.
  - If the updated value equals SYNC_WORD, the next state is DATA, with beat=0 and word=0.
  - The beat that completes the match is not data. The first ad_valid beat after it is data beat 0.
- DATA:
  - Each ad_valid beat k (0..63) fills shift[2k+1:2k] = {b2,b1}, so beat 0 occupies bits [1:0] (LSB-first).
  - On beat 63, the assembled word is presented the following cycle:
    - If full=0 in the beat-63 cycle: wr_en=1 and dout=word, one cycle after beat 63.
    - If full=1: wr_en stays 0, overflow pulses in that same next cycle, and drop_cnt increments.
  - full is sampled in the beat-63 cycle only. Latency from beat 63 to wr_en is 1 cycle.
  - After word WORDS_PER_FRAME-1 the state returns to HUNT with sync_sr cleared. Otherwise beat resets to 0 and collection continues with no gap; a beat in the write cycle is valid data for the next word.
- Timeout:
  - In DATA, the idle counter increments on every cycle with ad_valid=0 and clears on ad_valid=1.
  - When it reaches TIMEOUT, the partial word is discarded, timeout_err pulses, and the state returns to HUNT with sync_sr cleared.
  - If ad_valid=1 arrives in the same cycle as the timeout, the timeout wins and the beat is ignored.
- locked=1 exactly while state=DATA.
- wr_en is never asserted in HUNT and never for two consecutive cycles. dout holds its last value when wr_en=0.
- ad1/ad2 are ignored when ad_valid=0.

Decomposition:
- Package comm_pkg holds:
  - WORD_W=128, SAMPLE_W=6, BITS_PER_BEAT=2, BEATS_PER_WORD=64
  - the state enum {HUNT, DATA}
  - the default SYNC_WORD and THRESH constants, shared with the transmit block so both ends agree on framing.
- One natural sub-module: comm_recv_deser. It holds the 128-bit shift/beat counter and produces word_done plus the word; it is cleared by the top-level FSM.

Test Plan:
1. Reset: hold RST=1 for 2 cycles with random ad_valid/ad1/ad2 -> all outputs 0, locked=0, no wr_en.
2. Lock and single word:
   - Stimulus: send 8 beats encoding 16'hA5C3 (b=1 via 6'd63, b=0 via 6'd0), then 64 beats encoding 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, with full=0.
   - Required: locked rises the cycle after sync beat 8; one wr_en pulse with exactly that dout, 1 cycle after the last beat; then locked=0.
3. Threshold edges: data beats with ad1=31 and ad2=32 -> each sliced pair is {1,0}. With all 64 beats so, dout=128'hAAAA…AAAA.
4. Overflow:
   - Stimulus: same frame as scenario 2 with full=1 during the last beat.
   - Required: no wr_en, overflow pulses once, drop_cnt=1; the next frame with full=0 writes normally and drop_cnt stays 1.
5. Timeout: TIMEOUT=16; lock, send 10 data beats, then hold ad_valid=0 for 16 cycles -> timeout_err pulses once, locked=0, no wr_en; a following full frame is received correctly.
6. Multi-word frame:
   - Stimulus: WORDS_PER_FRAME=2; sync, then 128 contiguous beats with ad_valid=1 every cycle.
   - Required: two wr_en pulses 64 cycles apart with the correct words; a false near-match (16'hA5C2) in HUNT produces no lock.
